// File: rtl/sram_match_responder.sv
// sram_match_responder
//   SRAM-side responder for one write port's SRAM match. While the port is
//   matching it walks the 16 SRAMs one per cycle and presents availability,
//   free space and the per-destination packet count of each one. When the
//   matcher names a winner, that SRAM is locked for this port until a packet
//   is committed to it. Per-SRAM free space and per-(SRAM,dest) packet counts
//   are maintained from commit and release events.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   match_enable               port is matching (held for the whole match)
//   new_dest_port[3:0]         destination of pending packet, selects count column
//   match_sram[3:0]            SRAM index being presented
//   accessible                 presented SRAM is not locked by anyone
//   free_space[7:0]            free halfwords of presented SRAM
//   packet_amount[5:0]         packets for new_dest_port in presented SRAM
//   match_suc, match_best_sram matcher done pulse and winner (16 = none)
//   ext_lock_mask[15:0]        SRAMs locked by other write ports
//   own_lock_mask[15:0]        SRAM locked by this port (one-hot or zero)
//   wr_commit/wr_*             packet written, occupies wr_length+1 halfwords
//   rd_release/rd_*            packet read out, frees rd_length+1 halfwords
//   err                        sticky bookkeeping error
//
// State table
//   ST_IDLE | not matching, scan counter parked at 0
//   ST_SCAN | presenting one SRAM per cycle to the matcher
//   ST_WAIT | winner locked, waiting for the packet commit to that SRAM
module sram_match_responder #(
  parameter logic [7:0] CAPACITY = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        match_enable,
  input  logic [3:0]  new_dest_port,
  output logic [3:0]  match_sram,
  output logic        accessible,
  output logic [7:0]  free_space,
  output logic [5:0]  packet_amount,
  input  logic        match_suc,
  input  logic [4:0]  match_best_sram,
  input  logic [15:0] ext_lock_mask,
  output logic [15:0] own_lock_mask,
  input  logic        wr_commit,
  input  logic [3:0]  wr_sram,
  input  logic [4:0]  wr_length,
  input  logic [3:0]  wr_dest,
  input  logic        rd_release,
  input  logic [3:0]  rd_sram,
  input  logic [4:0]  rd_length,
  input  logic [3:0]  rd_dest,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [15:0]          own_lock_q, own_lock_d;
  logic [15:0][7:0]     free_q, free_d;
  logic [15:0][15:0][5:0] amt_q, amt_d;
  logic                 err_q, err_d;

  logic [3:0]           match_sram_q, match_sram_d;
  logic                 accessible_q, accessible_d;
  logic [7:0]           free_space_q, free_space_d;
  logic [5:0]           packet_amount_q, packet_amount_d;

  // Bookkeeping scratch
  logic                 hit_wr, hit_rd, inc, dec;
  logic [8:0]           up, dn, net;

  // FSM transitions and presentation
  always_comb begin
    state_d         = state_q;
    own_lock_d      = own_lock_q;
    cnt_d           = 4'd0;
    match_sram_d    = match_sram_q;
    free_space_d    = free_space_q;
    packet_amount_d = packet_amount_q;
    accessible_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (match_enable) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (match_suc) begin
          // Any index with bit 4 set (16 and above) means no winner.
          if (!match_best_sram[4]) begin
            own_lock_d = 16'd1 << match_best_sram[3:0];
            state_d    = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!match_enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wr_commit && own_lock_q[wr_sram]) begin
          own_lock_d = 16'd0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        own_lock_d = 16'd0;
      end
    endcase

    // Outputs are registered against the state being entered, so the
    // presented SRAM and its data always belong to the same cycle. Array
    // reads use the pre-update contents.
    if (state_d == ST_SCAN) begin
      match_sram_d    = cnt_q;
      free_space_d    = free_q[cnt_q];
      packet_amount_d = amt_q[cnt_q][new_dest_port];
      accessible_d    = ~own_lock_q[cnt_q] & ~ext_lock_mask[cnt_q];
      cnt_d           = cnt_q + 4'd1;
    end
  end

  // Free-space and packet-count bookkeeping
  always_comb begin
    free_d = free_q;
    amt_d  = amt_q;
    err_d  = err_q;
    hit_wr = 1'b0;
    hit_rd = 1'b0;
    inc    = 1'b0;
    dec    = 1'b0;
    up     = 9'd0;
    dn     = 9'd0;
    net    = 9'd0;

    for (int s = 0; s < 16; s++) begin
      hit_wr = wr_commit  && (wr_sram == 4'(s));
      hit_rd = rd_release && (rd_sram == 4'(s));

      // Release is added first so a same-SRAM commit/release pair saturates
      // once, on the net result.
      up = {1'b0, free_q[s]} + (hit_rd ? ({4'd0, rd_length} + 9'd1) : 9'd0);
      dn = hit_wr ? ({4'd0, wr_length} + 9'd1) : 9'd0;
      if (up < dn) begin
        free_d[s] = 8'd0;
        err_d     = 1'b1;
      end else begin
        net = up - dn;
        if (net > {1'b0, CAPACITY}) begin
          free_d[s] = CAPACITY;
          err_d     = 1'b1;
        end else begin
          free_d[s] = net[7:0];
        end
      end

      for (int d = 0; d < 16; d++) begin
        inc = hit_wr && (wr_dest == 4'(d));
        dec = hit_rd && (rd_dest == 4'(d));
        if (inc && !dec) begin
          if (amt_q[s][d] == 6'd63) err_d = 1'b1;
          else                      amt_d[s][d] = amt_q[s][d] + 6'd1;
        end else if (dec && !inc) begin
          if (amt_q[s][d] == 6'd0) err_d = 1'b1;
          else                     amt_d[s][d] = amt_q[s][d] - 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 4'd0;
      own_lock_q      <= 16'd0;
      for (int s = 0; s < 16; s++) free_q[s] <= CAPACITY;
      amt_q           <= '0;
      err_q           <= 1'b0;
      match_sram_q    <= 4'd0;
      accessible_q    <= 1'b0;
      free_space_q    <= 8'd0;
      packet_amount_q <= 6'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      own_lock_q      <= own_lock_d;
      free_q          <= free_d;
      amt_q           <= amt_d;
      err_q           <= err_d;
      match_sram_q    <= match_sram_d;
      accessible_q    <= accessible_d;
      free_space_q    <= free_space_d;
      packet_amount_q <= packet_amount_d;
    end
  end

  assign match_sram    = match_sram_q;
  assign accessible    = accessible_q;
  assign free_space    = free_space_q;
  assign packet_amount = packet_amount_q;
  assign own_lock_mask = own_lock_q;
  assign err           = err_q;

endmodule

// File: tb/tb_sram_match_responder.sv
module tb_sram_match_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        match_enable;
  logic [3:0]  new_dest_port;
  logic [3:0]  match_sram;
  logic        accessible;
  logic [7:0]  free_space;
  logic [5:0]  packet_amount;
  logic        match_suc;
  logic [4:0]  match_best_sram;
  logic [15:0] ext_lock_mask;
  logic [15:0] own_lock_mask;
  logic        wr_commit;
  logic [3:0]  wr_sram;
  logic [4:0]  wr_length;
  logic [3:0]  wr_dest;
  logic        rd_release;
  logic [3:0]  rd_sram;
  logic [4:0]  rd_length;
  logic [3:0]  rd_dest;
  logic        err;

  sram_match_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .match_enable    (match_enable),
    .new_dest_port   (new_dest_port),
    .match_sram      (match_sram),
    .accessible      (accessible),
    .free_space      (free_space),
    .packet_amount   (packet_amount),
    .match_suc       (match_suc),
    .match_best_sram (match_best_sram),
    .ext_lock_mask   (ext_lock_mask),
    .own_lock_mask   (own_lock_mask),
    .wr_commit       (wr_commit),
    .wr_sram         (wr_sram),
    .wr_length       (wr_length),
    .wr_dest         (wr_dest),
    .rd_release      (rd_release),
    .rd_sram         (rd_sram),
    .rd_length       (rd_length),
    .rd_dest         (rd_dest),
    .err             (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers, mode 0 idle / 1 scanning / 2 locked.
  int m_free [16];
  int m_amt  [16][16];
  int m_mode;
  int m_cnt;
  int m_lock;
  int m_err;
  int e_sram, e_acc, e_free, e_amt;

  function automatic void model_reset();
    for (int s = 0; s < 16; s++) begin
      m_free[s] = 255;
      for (int d = 0; d < 16; d++) m_amt[s][d] = 0;
    end
    m_mode = 0; m_cnt = 0; m_lock = -1; m_err = 0;
    e_sram = 0; e_acc = 0; e_free = 0; e_amt = 0;
  endfunction

  function automatic void model_edge();
    int nxt;
    int dfree [16];
    int damt  [16][16];
    int v;
    if (!rst_n) begin
      model_reset();
      return;
    end
    nxt = m_mode;
    case (m_mode)
      0: if (match_enable) nxt = 1;
      1: begin
        if (match_suc && int'(match_best_sram) < 16) begin
          m_lock = int'(match_best_sram);
          nxt = 2;
        end else if (match_suc || !match_enable) begin
          nxt = 0;
        end
      end
      default: if (wr_commit && int'(wr_sram) == m_lock) begin
        m_lock = -1;
        nxt = 0;
      end
    endcase
    m_mode = nxt;
    if (nxt == 1) begin
      e_sram = m_cnt;
      e_free = m_free[m_cnt];
      e_amt  = m_amt[m_cnt][new_dest_port];
      e_acc  = (m_lock != m_cnt && !ext_lock_mask[m_cnt]) ? 1 : 0;
      m_cnt  = (m_cnt + 1) % 16;
    end else begin
      e_acc = 0;
      m_cnt = 0;
    end
    for (int s = 0; s < 16; s++) begin
      dfree[s] = 0;
      for (int d = 0; d < 16; d++) damt[s][d] = 0;
    end
    if (wr_commit) begin
      dfree[wr_sram] -= int'(wr_length) + 1;
      damt[wr_sram][wr_dest] += 1;
    end
    if (rd_release) begin
      dfree[rd_sram] += int'(rd_length) + 1;
      damt[rd_sram][rd_dest] -= 1;
    end
    for (int s = 0; s < 16; s++) begin
      v = m_free[s] + dfree[s];
      if (v < 0)   begin v = 0;   m_err = 1; end
      if (v > 255) begin v = 255; m_err = 1; end
      m_free[s] = v;
      for (int d = 0; d < 16; d++) begin
        v = m_amt[s][d] + damt[s][d];
        if (v > 63) begin v = 63; m_err = 1; end
        if (v < 0)  begin v = 0;  m_err = 1; end
        m_amt[s][d] = v;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".match_sram"},    32'(match_sram),    32'(e_sram));
    chk({tag, ".accessible"},    32'(accessible),    32'(e_acc));
    chk({tag, ".free_space"},    32'(free_space),    32'(e_free));
    chk({tag, ".packet_amount"}, 32'(packet_amount), 32'(e_amt));
    chk({tag, ".own_lock_mask"}, 32'(own_lock_mask), (m_lock < 0) ? 32'd0 : (32'd1 << m_lock));
    chk({tag, ".err"},           32'(err),           32'(m_err));
  endtask

  task automatic clear_pulses();
    match_suc  = 1'b0;
    wr_commit  = 1'b0;
    rd_release = 1'b0;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; match_enable = 1'b0; new_dest_port = 4'd0;
    match_suc = 1'b0; match_best_sram = 5'd16; ext_lock_mask = 16'h0;
    wr_commit = 1'b0; wr_sram = 4'd0; wr_length = 5'd0; wr_dest = 4'd0;
    rd_release = 1'b0; rd_sram = 4'd0; rd_length = 5'd0; rd_dest = 4'd0;

    // Reset state
    step("rst"); step("rst");
    chk("rst_free_space", 32'(free_space), 32'd0);
    chk("rst_own_lock", 32'(own_lock_mask), 32'd0);
    rst_n = 1'b1;

    // Plain scan, 20 cycles
    match_enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step("scan");
      chk("scan_idx", 32'(match_sram), 32'(k % 16));
      chk("scan_acc", 32'(accessible), 32'd1);
      chk("scan_free", 32'(free_space), 32'd255);
    end
    match_enable = 1'b0;
    step("scan_stop");
    chk("scan_stop_acc", 32'(accessible), 32'd0);

    // External lock masking, then win SRAM 7
    ext_lock_mask = 16'h0010;
    match_enable  = 1'b1;
    for (int k = 0; k < 18; k++) begin
      step("mask");
      chk("mask_acc", 32'(accessible), ((k % 16) != 4) ? 32'd1 : 32'd0);
    end
    match_suc = 1'b1; match_best_sram = 5'd7;
    step("win");
    clear_pulses();
    chk("win_lock", 32'(own_lock_mask), 32'h0080);
    for (int k = 0; k < 3; k++) begin
      step("wait");
      chk("wait_acc", 32'(accessible), 32'd0);
    end
    wr_commit = 1'b1; wr_sram = 4'd3; wr_length = 5'd0; wr_dest = 4'd0;
    step("commit3");
    clear_pulses();
    chk("commit3_lock", 32'(own_lock_mask), 32'h0080);
    step("wait2");
    wr_commit = 1'b1; wr_sram = 4'd7;
    step("commit7");
    clear_pulses();
    match_enable = 1'b0;
    ext_lock_mask = 16'h0;
    chk("commit7_lock", 32'(own_lock_mask), 32'd0);
    step("idle");

    // Commit then release on SRAM 2 / dest 5
    wr_commit = 1'b1; wr_sram = 4'd2; wr_length = 5'd9; wr_dest = 4'd5;
    step("bk_wr");
    clear_pulses();
    new_dest_port = 4'd5; match_enable = 1'b1;
    step("bk_s"); step("bk_s"); step("bk_s");
    chk("bk_free", 32'(free_space), 32'd245);
    chk("bk_amt", 32'(packet_amount), 32'd1);
    match_enable = 1'b0;
    step("bk_stop");
    rd_release = 1'b1; rd_sram = 4'd2; rd_length = 5'd9; rd_dest = 4'd5;
    step("bk_rd");
    clear_pulses();
    match_enable = 1'b1;
    step("bk_s2"); step("bk_s2"); step("bk_s2");
    chk("bk_rd_free", 32'(free_space), 32'd255);
    chk("bk_rd_amt", 32'(packet_amount), 32'd0);
    match_enable = 1'b0;
    step("bk_stop2");

    // Simultaneous commit and release on SRAM 1, same dest
    wr_commit = 1'b1; wr_sram = 4'd1; wr_length = 5'd20; wr_dest = 4'd4;
    step("sim_prior");
    wr_length = 5'd3;
    rd_release = 1'b1; rd_sram = 4'd1; rd_length = 5'd7; rd_dest = 4'd4;
    step("sim_both");
    clear_pulses();
    new_dest_port = 4'd4; match_enable = 1'b1;
    step("sim_s"); step("sim_s");
    chk("sim_free", 32'(free_space), 32'd238);
    chk("sim_amt", 32'(packet_amount), 32'd1);
    chk("sim_err", 32'(err), 32'd0);
    match_enable = 1'b0;
    step("sim_stop");

    // Release to an empty SRAM 0
    rd_release = 1'b1; rd_sram = 4'd0; rd_length = 5'd0; rd_dest = 4'd0;
    step("err_rd");
    clear_pulses();
    chk("err_set", 32'(err), 32'd1);
    new_dest_port = 4'd0; match_enable = 1'b1;
    step("err_s");
    chk("err_free", 32'(free_space), 32'd255);
    chk("err_amt", 32'(packet_amount), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step("err_hold");
      chk("err_sticky", 32'(err), 32'd1);
    end
    match_enable = 1'b0;
    step("err_stop");

    // No winner, then reset while locked
    match_enable = 1'b1;
    step("nw"); step("nw");
    match_suc = 1'b1; match_best_sram = 5'd16;
    step("nw_suc");
    clear_pulses();
    chk("nw_lock", 32'(own_lock_mask), 32'd0);
    chk("nw_acc", 32'(accessible), 32'd0);
    match_enable = 1'b0;
    step("nw_idle");
    match_enable = 1'b1;
    step("rl"); step("rl"); step("rl");
    match_suc = 1'b1; match_best_sram = 5'd5;
    step("rl_win");
    clear_pulses();
    chk("rl_lock", 32'(own_lock_mask), 32'h0020);
    wr_commit = 1'b1; wr_sram = 4'd9; wr_length = 5'd2; wr_dest = 4'd1;
    step("rl_other");
    clear_pulses();
    rst_n = 1'b0;
    step("rl_rst");
    chk("rl_rst_lock", 32'(own_lock_mask), 32'd0);
    chk("rl_rst_acc", 32'(accessible), 32'd0);
    chk("rl_rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step("rl_s"); step("rl_s");
    chk("rl_rst_free1", 32'(free_space), 32'd255);
    match_enable = 1'b0;
    step("rl_stop");

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 15) == 0) match_enable = ~match_enable;
      match_suc       = ($urandom_range(0, 11) == 0);
      match_best_sram = 5'($urandom_range(0, 16));
      ext_lock_mask   = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
      new_dest_port   = 4'($urandom);
      wr_commit       = ($urandom_range(0, 2) == 0);
      wr_sram         = (m_lock >= 0 && $urandom_range(0, 1) == 0) ? 4'(m_lock) : 4'($urandom_range(0, 3));
      wr_length       = 5'($urandom);
      wr_dest         = 4'($urandom_range(0, 3));
      rd_release      = ($urandom_range(0, 2) == 0);
      rd_sram         = ($urandom_range(0, 1) == 0) ? wr_sram : 4'($urandom_range(0, 3));
      rd_length       = 5'($urandom);
      rd_dest         = ($urandom_range(0, 1) == 0) ? wr_dest : 4'($urandom_range(0, 3));
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
